// File: rtl/shared_adder_sched.sv
// Round-robin scheduler that time-shares one signed add/sub datapath among N_REQ
// requesters, returning id-tagged results through a single registered output slot.
module shared_adder_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int FRAC  = 14,
  parameter int SAT   = 1,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  input  logic [N_REQ-1:0]         req_sub,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_q,
  output logic [ID_W-1:0]          res_id,
  output logic                     res_ovf,
  output logic [N_REQ-1:0]         ovf_sticky,
  input  logic                     ovf_clr
);

  // Handshake: a requester transfers on req_valid[i] && req_ready[i]; the result
  // slot is consumed on res_valid && res_ready, and may be refilled on the same edge.

  // FRAC only names the Q format; the add/sub itself is format-agnostic.
  if (FRAC < 0 || FRAC >= WIDTH) begin : g_frac_out_of_range
  end

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   ptr_next;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   cand_id;
  logic [ID_W:0]     cand;
  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  sticky_next;
  logic              found;
  logic              slot_free;
  logic              xfer;
  logic [WIDTH-1:0]  a_sel;
  logic [WIDTH-1:0]  b_sel;
  logic              sub_sel;
  logic [WIDTH:0]    ext_a;
  logic [WIDTH:0]    ext_b;
  logic [WIDTH:0]    sum;
  logic              ovf;
  logic [WIDTH-1:0]  sat_val;
  logic [WIDTH-1:0]  q_next;

  assign slot_free = !res_valid || res_ready;

  // Scan upward from ptr with wrap; the first valid requester wins.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    cand_id = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      cand_id = cand[ID_W-1:0];
      if (!found && req_valid[cand_id]) begin
        found   = 1'b1;
        gnt_idx = cand_id;
      end
    end
    if (found && slot_free && !rst) grant[gnt_idx] = 1'b1;
  end

  assign req_ready = grant;
  assign xfer      = |grant;
  assign ptr_next  = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    a_sel   = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
    b_sel   = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
    sub_sel = req_sub[gnt_idx];
    ext_a   = {a_sel[WIDTH-1], a_sel};
    ext_b   = {b_sel[WIDTH-1], b_sel};
    // One guard bit keeps a - (most negative) exact before the overflow test.
    sum     = sub_sel ? (ext_a - ext_b) : (ext_a + ext_b);
    ovf     = sum[WIDTH] ^ sum[WIDTH-1];
    sat_val = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    q_next  = ((SAT != 0) && ovf) ? sat_val : sum[WIDTH-1:0];
  end

  // A set from this cycle's transfer takes priority over the clear pulse.
  assign sticky_next = (ovf_clr ? '0 : ovf_sticky) | ((xfer && ovf) ? grant : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      res_valid  <= 1'b0;
      res_q      <= '0;
      res_id     <= '0;
      res_ovf    <= 1'b0;
      ovf_sticky <= '0;
    end else begin
      ovf_sticky <= sticky_next;
      if (xfer) begin
        ptr       <= ptr_next;
        res_valid <= 1'b1;
        res_q     <= q_next;
        res_id    <= gnt_idx;
        res_ovf   <= ovf;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
